// File: rtl/param_accum_processor.sv
// Multi-cycle accumulator processor: LOAD/STORE/ADD/SUB/IN/JZ/JPOS/HALT over one program/data memory.
// Optional PAP_OVF_HALT_EN: signed ADD/SUB overflow keeps A, raises Fault and halts.
module param_accum_processor #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = DATA_W - 3
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Enter,
  input  logic [DATA_W-1:0] Input,
  input  logic              ProgWe,
  input  logic [ADDR_W-1:0] ProgAddr,
  input  logic [DATA_W-1:0] ProgData,
  output logic [DATA_W-1:0] Output,
  output logic              InAck,
  output logic              Halt,
  output logic              Busy,
  output logic              Fault,
  output logic [ADDR_W-1:0] PC,
  output logic [2:0]        State
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_INWAIT = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    OP_LOAD  = 3'b000,
    OP_STORE = 3'b001,
    OP_ADD   = 3'b010,
    OP_SUB   = 3'b011,
    OP_IN    = 3'b100,
    OP_JZ    = 3'b101,
    OP_JPOS  = 3'b110,
    OP_HALT  = 3'b111
  } opcode_t;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              in_ack_q, in_ack_d;
  logic              enter_q;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  opcode_t           opcode;
  logic [ADDR_W-1:0] operand_addr;
  logic [DATA_W-1:0] operand;
  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;
  logic              enter_rise;

  assign opcode       = opcode_t'(ir_q[DATA_W-1:DATA_W-3]);
  assign operand_addr = ir_q[ADDR_W-1:0];
  assign operand      = mem[operand_addr];
  assign sum          = a_q + operand;
  assign diff         = a_q - operand;
  assign enter_rise   = Enter & ~enter_q;

`ifdef PAP_OVF_HALT_EN
  logic fault_q, fault_d;
  logic add_ovf, sub_ovf;

  // Signed overflow: operands agree (ADD) or differ (SUB) in sign and the result sign flips.
  assign add_ovf = (a_q[DATA_W-1] == operand[DATA_W-1]) && (sum[DATA_W-1]  != a_q[DATA_W-1]);
  assign sub_ovf = (a_q[DATA_W-1] != operand[DATA_W-1]) && (diff[DATA_W-1] != a_q[DATA_W-1]);
`endif

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    a_d       = a_q;
    ir_d      = ir_q;
    in_ack_d  = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = ProgAddr;
    mem_wdata = ProgData;
`ifdef PAP_OVF_HALT_EN
    fault_d   = fault_q;
`endif

    case (state_q)
      S_IDLE, S_HALT: begin
        mem_we = ProgWe;
        if (Start) begin
          pc_d    = '0;
          a_d     = '0;
          state_d = S_FETCH;
`ifdef PAP_OVF_HALT_EN
          fault_d = 1'b0;
`endif
        end
      end

      S_FETCH: begin
        ir_d    = mem[pc_q];
        pc_d    = pc_q + 1'b1;
        state_d = S_DECODE;
      end

      S_DECODE: begin
        case (opcode)
          OP_IN:   state_d = S_INWAIT;
          OP_HALT: state_d = S_HALT;
          OP_JZ: begin
            if (a_q == '0) pc_d = operand_addr;
            state_d = S_FETCH;
          end
          OP_JPOS: begin
            if (!a_q[DATA_W-1] && (a_q != '0)) pc_d = operand_addr;
            state_d = S_FETCH;
          end
          default: state_d = S_EXEC;
        endcase
      end

      S_EXEC: begin
        state_d = S_FETCH;
        case (opcode)
          OP_LOAD: a_d = operand;
          OP_STORE: begin
            mem_we    = 1'b1;
            mem_waddr = operand_addr;
            mem_wdata = a_q;
          end
          OP_ADD: begin
`ifdef PAP_OVF_HALT_EN
            if (add_ovf) begin
              fault_d = 1'b1;
              state_d = S_HALT;
            end else begin
              a_d = sum;
            end
`else
            a_d = sum;
`endif
          end
          OP_SUB: begin
`ifdef PAP_OVF_HALT_EN
            if (sub_ovf) begin
              fault_d = 1'b1;
              state_d = S_HALT;
            end else begin
              a_d = diff;
            end
`else
            a_d = diff;
`endif
          end
          default: ;
        endcase
      end

      S_INWAIT: begin
        if (enter_rise) begin
          a_d      = Input;
          in_ack_d = 1'b1;
          state_d  = S_FETCH;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      a_q      <= '0;
      ir_q     <= '0;
      in_ack_q <= 1'b0;
      enter_q  <= 1'b0;
`ifdef PAP_OVF_HALT_EN
      fault_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      a_q      <= a_d;
      ir_q     <= ir_d;
      in_ack_q <= in_ack_d;
      enter_q  <= Enter;
`ifdef PAP_OVF_HALT_EN
      fault_q  <= fault_d;
`endif
    end
  end

  // NOTE: the memory has no reset; program and data survive a reset.
  always_ff @(posedge Clock) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign Output = a_q;
  assign InAck  = in_ack_q;
  assign Halt   = (state_q == S_HALT);
  assign Busy   = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                  (state_q == S_EXEC)  || (state_q == S_INWAIT);
  assign PC     = pc_q;
  assign State  = state_q;
`ifdef PAP_OVF_HALT_EN
  assign Fault  = fault_q;
`else
  assign Fault  = 1'b0;
`endif

endmodule

// File: tb/tb_param_accum_processor.sv
// Bench for param_accum_processor (DATA_W=8): directed scenarios plus random forward-only
// programs checked against an instruction-level reference interpreter.
module tb_param_accum_processor;

  localparam int DW    = 8;
  localparam int AW    = 5;
  localparam int DEPTH = 32;
`ifdef PAP_OVF_HALT_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, enter, prog_we;
  logic [DW-1:0] in_data, prog_data, out_a;
  logic [AW-1:0] prog_addr, pc;
  logic          in_ack, halt, busy, fault;
  logic [2:0]    state;

  param_accum_processor #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .Clock(clk), .Reset(rst_n), .Start(start), .Enter(enter), .Input(in_data),
    .ProgWe(prog_we), .ProgAddr(prog_addr), .ProgData(prog_data),
    .Output(out_a), .InAck(in_ack), .Halt(halt), .Busy(busy), .Fault(fault),
    .PC(pc), .State(state)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] prog [DEPTH];
  logic [DW-1:0] dut_in[$];

  // Reference interpreter state
  logic [DW-1:0] m_mem [DEPTH];
  logic [DW-1:0] m_in[$];
  logic [DW-1:0] m_a;
  logic [AW-1:0] m_pc;
  bit            m_fault, m_halted;
  int            m_cycles, m_ins;

  function automatic logic [DW-1:0] enc(input logic [2:0] op, input logic [AW-1:0] ad);
    return {op, ad};
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < DEPTH; i++) prog[i] = '0;
  endtask

  task automatic load_all();
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      prog_we = 1'b1; prog_addr = i[AW-1:0]; prog_data = prog[i];
      m_mem[i] = prog[i];
    end
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  // Executes the program in m_mem instruction by instruction; cycles exclude INWAIT stalls.
  task automatic model_run();
    logic [DW-1:0] w, opnd;
    logic [2:0]    op;
    logic [AW-1:0] ad;
    int            s;
    m_a = '0; m_pc = '0; m_fault = 0; m_halted = 0; m_cycles = 0; m_ins = 0;
    for (int step = 0; step < 500 && !m_halted; step++) begin
      w = m_mem[m_pc]; m_pc = m_pc + 1'b1;
      op = w[7:5]; ad = w[4:0]; opnd = m_mem[ad];
      case (op)
        3'd0: begin m_a = opnd; m_cycles += 3; end
        3'd1: begin m_mem[ad] = m_a; m_cycles += 3; end
        3'd2, 3'd3: begin
          m_cycles += 3;
          if (op == 3'd2) s = int'($signed(m_a)) + int'($signed(opnd));
          else            s = int'($signed(m_a)) - int'($signed(opnd));
          if (OVF_EN && (s > 127 || s < -128)) begin m_fault = 1; m_halted = 1; end
          else m_a = s[7:0];
        end
        3'd4: begin m_a = (m_in.size() > 0) ? m_in.pop_front() : '0; m_ins++; m_cycles += 2; end
        3'd5: begin if (m_a == 0) m_pc = ad; m_cycles += 2; end
        3'd6: begin if (m_a != 0 && m_a < 8'h80) m_pc = ad; m_cycles += 2; end
        default: begin m_halted = 1; m_cycles += 2; end
      endcase
    end
  endtask

  // Pulses Start, answers every IN with a fresh Enter edge, runs to HALT within a cycle budget.
  task automatic run_dut(output int cyc, output int acks);
    bit ok;
    cyc = 0; acks = 0; ok = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (halt) begin ok = 1; break; end
      if (busy && state != 3'd4) cyc++;
      if (in_ack) acks++;
      if (enter) enter = 1'b0;
      else if (state == 3'd4) begin
        enter = 1'b1;
        in_data = (dut_in.size() > 0) ? dut_in.pop_front() : '0;
      end
      @(negedge clk);
    end
    enter = 1'b0;
    n_tests++;
    if (!ok) begin $display("FAIL run_timeout halt=%0b state=%0d pc=%0d", halt, state, pc); n_fail++; end
  endtask

  task automatic read_word(input int addr, output logic [DW-1:0] v);
    int c, a;
    @(negedge clk);
    prog_we = 1'b1; prog_addr = '0; prog_data = enc(3'd0, addr[AW-1:0]);
    @(negedge clk);
    prog_addr = 5'd1; prog_data = enc(3'd7, '0);
    @(negedge clk);
    prog_we = 1'b0;
    run_dut(c, a);
    v = out_a;
  endtask

  task automatic wait_state(input logic [2:0] s);
    for (int k = 0; k < 20 && state != s; k++) @(negedge clk);
    n_tests++;
    if (state !== s) begin $display("FAIL wait_state got %0d want %0d", state, s); n_fail++; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 0; enter = 0; prog_we = 0; in_data = '0; prog_addr = '0; prog_data = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({state, pc, out_a} !== '0) begin
      $display("FAIL reset_regs got state=%0d pc=%0d a=%0h want 0/0/0", state, pc, out_a); n_fail++;
    end
    n_tests++;
    if ({in_ack, halt, busy, fault} !== 4'b0) begin
      $display("FAIL reset_flags got %b want 0000", {in_ack, halt, busy, fault}); n_fail++;
    end
  endtask

  task automatic test_in_add_store();
    int cyc, acks;
    logic [DW-1:0] v;
    clear_prog();
    prog[0] = enc(3'd4, 5'd0); prog[1] = enc(3'd2, 5'd30);
    prog[2] = enc(3'd1, 5'd31); prog[3] = enc(3'd7, 5'd0); prog[30] = 8'd5;
    load_all();
    m_in = {8'd7}; dut_in = {8'd7};
    model_run();
    run_dut(cyc, acks);
    n_tests++;
    if (acks != 1) begin $display("FAIL in_acks got %0d want 1", acks); n_fail++; end
    n_tests++;
    if (out_a !== 8'd12 || halt !== 1'b1) begin
      $display("FAIL in_add_out got a=%0d halt=%0b want 12/1", out_a, halt); n_fail++;
    end
    n_tests++;
    if (cyc != m_cycles) begin $display("FAIL in_add_cycles got %0d want %0d", cyc, m_cycles); n_fail++; end
    read_word(31, v);
    n_tests++;
    if (v !== 8'd12) begin $display("FAIL store_m31 got %0d want 12", v); n_fail++; end
  endtask

  task automatic test_jumps();
    int cyc, acks;
    for (int t = 0; t < 2; t++) begin
      clear_prog();
      prog[0] = enc(3'd0, 5'd30); prog[1] = enc(3'd5, 5'd4);
      prog[2] = enc(3'd7, 5'd0);  prog[4] = enc(3'd7, 5'd0);
      prog[30] = t[7:0];
      load_all();
      model_run();
      run_dut(cyc, acks);
      n_tests++;
      if (pc !== ((t == 0) ? 5'd5 : 5'd3)) begin
        $display("FAIL jz_pc m30=%0d got %0d want %0d", t, pc, (t == 0) ? 5 : 3); n_fail++;
      end
      n_tests++;
      if (cyc != m_cycles) begin $display("FAIL jz_cycles got %0d want %0d", cyc, m_cycles); n_fail++; end
    end
  endtask

  task automatic test_pc_wrap();
    int cyc, acks;
    clear_prog();
    prog[0] = enc(3'd0, 5'd28); prog[1] = enc(3'd1, 5'd0);   // plant HALT at M0
    prog[2] = enc(3'd0, 5'd29); prog[3] = enc(3'd6, 5'd31);
    prog[28] = enc(3'd7, 5'd0); prog[29] = 8'd1; prog[30] = 8'h42;
    prog[31] = enc(3'd0, 5'd30);
    load_all();
    model_run();
    run_dut(cyc, acks);
    n_tests++;
    if (pc !== 5'd1 || out_a !== 8'h42 || halt !== 1'b1) begin
      $display("FAIL pc_wrap got pc=%0d a=%0h halt=%0b want 1/42/1", pc, out_a, halt); n_fail++;
    end
    n_tests++;
    if (cyc != m_cycles) begin $display("FAIL pc_wrap_cycles got %0d want %0d", cyc, m_cycles); n_fail++; end
  endtask

  task automatic test_busy_ignore();
    int cyc, acks;
    logic [DW-1:0] v;
    clear_prog();
    prog[0] = enc(3'd4, 5'd0); prog[1] = enc(3'd7, 5'd0); prog[25] = 8'h33;
    load_all();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_state(3'd4);
    start = 1'b1; prog_we = 1'b1; prog_addr = 5'd25; prog_data = 8'hAA;
    @(negedge clk);
    start = 1'b0; prog_we = 1'b0;
    n_tests++;
    if (state !== 3'd4 || pc !== 5'd1) begin
      $display("FAIL start_while_busy got state=%0d pc=%0d want 4/1", state, pc); n_fail++;
    end
    enter = 1'b1; in_data = 8'h21;
    @(negedge clk);
    enter = 1'b0;
    n_tests++;
    if (in_ack !== 1'b1 || out_a !== 8'h21) begin
      $display("FAIL busy_capture got ack=%0b a=%0h want 1/21", in_ack, out_a); n_fail++;
    end
    wait_state(3'd5);
    read_word(25, v);
    n_tests++;
    if (v !== 8'h33) begin $display("FAIL progwe_while_busy got %0h want 33", v); n_fail++; end
  endtask

  task automatic test_enter_and_reset();
    int acks;
    logic [DW-1:0] v;
    clear_prog();
    prog[0] = enc(3'd0, 5'd20); prog[1] = enc(3'd4, 5'd0); prog[2] = enc(3'd7, 5'd0);
    prog[20] = 8'h9C;
    load_all();
    enter = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_state(3'd4);
    acks = 0;
    repeat (5) begin if (in_ack) acks++; @(negedge clk); end
    n_tests++;
    if (acks != 0 || state !== 3'd4 || out_a !== 8'h9C) begin
      $display("FAIL enter_held got acks=%0d state=%0d a=%0h want 0/4/9c", acks, state, out_a); n_fail++;
    end
    enter = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (state !== 3'd4 || in_ack !== 1'b0) begin
      $display("FAIL enter_fall got state=%0d ack=%0b want 4/0", state, in_ack); n_fail++;
    end
    enter = 1'b1; in_data = 8'h5A;
    @(negedge clk);
    n_tests++;
    if (in_ack !== 1'b1 || out_a !== 8'h5A) begin
      $display("FAIL enter_edge got ack=%0b a=%0h want 1/5a", in_ack, out_a); n_fail++;
    end
    @(negedge clk);
    n_tests++;
    if (in_ack !== 1'b0) begin $display("FAIL inack_pulse got %0b want 0", in_ack); n_fail++; end
    enter = 1'b0;
    wait_state(3'd5);
    // Reset asserted mid-cycle while parked in INWAIT
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_state(3'd4);
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (state !== 3'd0 || out_a !== '0 || pc !== '0 || busy !== 1'b0) begin
      $display("FAIL async_reset got state=%0d a=%0h pc=%0d busy=%0b want 0/0/0/0", state, out_a, pc, busy);
      n_fail++;
    end
    @(negedge clk); rst_n = 1'b1;
    read_word(20, v);
    n_tests++;
    if (v !== 8'h9C) begin $display("FAIL mem_retained got %0h want 9c", v); n_fail++; end
  endtask

  task automatic test_overflow();
    int cyc, acks;
    for (int t = 0; t < 2; t++) begin
      clear_prog();
      prog[0] = enc(3'd0, 5'd30);
      prog[1] = enc((t == 0) ? 3'd2 : 3'd3, 5'd29);
      prog[2] = enc(3'd7, 5'd0);
      prog[29] = 8'h01;
      prog[30] = (t == 0) ? 8'h7F : 8'h80;
      load_all();
      run_dut(cyc, acks);
      n_tests++;
      if (OVF_EN) begin
        if (fault !== 1'b1 || halt !== 1'b1 || out_a !== prog[30] || pc !== 5'd2) begin
          $display("FAIL ovf_halt t=%0d got f=%0b h=%0b a=%0h pc=%0d want 1/1/%0h/2", t, fault, halt, out_a, pc, prog[30]);
          n_fail++;
        end
      end else begin
        if (fault !== 1'b0 || out_a !== ((t == 0) ? 8'h80 : 8'h7F) || pc !== 5'd3) begin
          $display("FAIL ovf_wrap t=%0d got f=%0b a=%0h pc=%0d", t, fault, out_a, pc);
          n_fail++;
        end
      end
    end
    clear_prog();
    prog[0] = enc(3'd7, 5'd0);
    load_all();
    run_dut(cyc, acks);
    n_tests++;
    if (fault !== 1'b0) begin $display("FAIL fault_clear got %0b want 0", fault); n_fail++; end
  endtask

  task automatic test_random();
    int cyc, acks, da;
    logic [2:0] op;
    logic [DW-1:0] v;
    for (int it = 0; it < 10; it++) begin
      clear_prog();
      for (int i = 0; i < 20; i++) begin
        op = 3'($urandom_range(0, 6));
        if (op == 3'd5 || op == 3'd6) prog[i] = enc(op, 5'($urandom_range(i + 1, 20)));
        else                          prog[i] = enc(op, 5'($urandom_range(21, 31)));
      end
      prog[20] = enc(3'd7, 5'd0);
      for (int i = 21; i < DEPTH; i++) prog[i] = 8'($urandom);
      load_all();
      m_in.delete(); dut_in.delete();
      for (int i = 0; i < 20; i++) begin
        v = 8'($urandom);
        m_in.push_back(v); dut_in.push_back(v);
      end
      model_run();
      run_dut(cyc, acks);
      n_tests++;
      if (out_a !== m_a || pc !== m_pc || fault !== m_fault) begin
        $display("FAIL rand%0d_state got a=%0h pc=%0d f=%0b want %0h/%0d/%0b", it, out_a, pc, fault, m_a, m_pc, m_fault);
        n_fail++;
      end
      n_tests++;
      if (cyc != m_cycles || acks != m_ins) begin
        $display("FAIL rand%0d_timing got cyc=%0d acks=%0d want %0d/%0d", it, cyc, acks, m_cycles, m_ins);
        n_fail++;
      end
      da = $urandom_range(21, 31);
      read_word(da, v);
      n_tests++;
      if (v !== m_mem[da]) begin
        $display("FAIL rand%0d_mem%0d got %0h want %0h", it, da, v, m_mem[da]); n_fail++;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_in_add_store();
    test_jumps();
    test_pc_wrap();
    test_busy_ignore();
    test_enter_and_reset();
    test_overflow();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/param_accum_processor.md
PARAM_ACCUM_PROCESSOR -- requirements
Module: param_accum_processor

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DATA_W, 8, accumulator, memory word and instruction width; legal range 6..16.
- ADDR_W, DATA_W-3, PC and memory address width; memory depth is 2^ADDR_W words.
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
- Clock  in  1  single clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Start  in  1  begin execution from address 0; honoured only in IDLE or HALT.
- Enter  in  1  synchronous operator strobe; its rising edge completes IN.
- Input  in  DATA_W  operator data.
- ProgWe  in  1  program-load write enable.
- ProgAddr  in  ADDR_W  program-load address.
- ProgData  in  DATA_W  program-load data.
- Output  out  DATA_W  accumulator A, registered.
- InAck  out  1  one-cycle pulse when IN captures Input.
- Halt  out  1  high in HALT.
- Busy  out  1  high in FETCH, DECODE, EXEC or INWAIT.
- Fault  out  1  overflow fault flag; constant 0 when PAP_OVF_HALT_EN is undefined.
- PC  out  ADDR_W  program counter.
- State  out  3  FSM state code.

Function
REQ-003 Instruction format SHALL be opcode = IR[DATA_W-1:DATA_W-3], operand address = IR[ADDR_W-1:0].
REQ-004 Opcodes SHALL be: 000 LOAD A<=M[a]; 001 STORE M[a]<=A; 010 ADD A<=A+M[a]; 011 SUB A<=A-M[a]; 100 IN A<=Input; 101 JZ; 110 JPOS; 111 HALT.
REQ-005 Memory SHALL be 2^ADDR_W x DATA_W, combinational read, synchronous write.
REQ-006 FSM states and codes SHALL be IDLE=0, FETCH=1, DECODE=2, EXEC=3, INWAIT=4, HALT=5.
REQ-007 IDLE/HALT with Start=1 SHALL set PC<=0 and A<=0, then enter FETCH; otherwise the state is held.
REQ-008 FETCH SHALL load IR<=M[PC] and set PC<=PC+1 modulo 2^ADDR_W, so PC wraps from all-ones to 0.
REQ-009 DECODE SHALL dispatch as follows: IN -> INWAIT; HALT -> HALT; JZ taken when A==0; JPOS taken when A[DATA_W-1]==0 and A!=0; a taken jump sets PC<=address; jumps and not-taken jumps -> FETCH; all other opcodes -> EXEC.
REQ-010 EXEC SHALL perform LOAD, STORE, ADD or SUB in one cycle and then go to FETCH; arithmetic is modulo 2^DATA_W.
REQ-011 Instruction latency SHALL be 3 cycles for LOAD/STORE/ADD/SUB and 2 cycles for jumps and HALT.
REQ-012 INWAIT SHALL wait for an Enter rising edge (Enter=1 with the previous-cycle Enter=0).
- On that edge: A<=Input, InAck=1 for exactly one cycle, next state FETCH.
- Enter already high on arrival does not complete IN; a fresh edge is required.
REQ-013 ProgWe SHALL write M[ProgAddr]<=ProgData only in IDLE or HALT and SHALL be ignored in every other state.
REQ-014 ProgWe and Start asserted in the same cycle SHALL both take effect, and the following FETCH reads the newly written data.
REQ-015 STORE to the address of a later instruction SHALL be visible to that later FETCH (self-modifying code).
REQ-016 Start asserted while Busy SHALL be ignored.

Reset
REQ-017 Reset low SHALL immediately force State=IDLE, PC=0, A=0, IR=0, InAck=0, Fault=0, Halt=0 and clear the Enter-edge history, including mid-instruction.
REQ-018 Memory contents SHALL NOT be altered by reset.

Configuration
REQ-019 With PAP_OVF_HALT_EN defined, signed overflow on ADD or SUB SHALL leave A unmodified, set Fault=1 and enter HALT.
- Fault clears only on Start or reset.
REQ-020 With PAP_OVF_HALT_EN undefined, ADD and SUB SHALL wrap silently and Fault SHALL be tied to 0.

Verification
REQ-021 Load M0=IN, M1=ADD 30, M2=STORE 31, M3=HALT, M30=5; Start; pulse Enter with Input=7 -> InAck pulses once, M31=12, Output=12, Halt=1.
REQ-022 Program M0=LOAD 30, M1=JZ 4, M2=HALT, M4=HALT with M30=0 -> PC=5 in HALT; repeat with M30=1 -> PC=3 in HALT.
REQ-023 PC wrap: M31=LOAD 30, M0=HALT, start execution at 31 via a JPOS with A positive -> PC wraps 31->0 and then halts with PC=1.
REQ-024 Hold Enter high before IN is reached -> no capture until Enter falls and rises; assert Reset low in INWAIT -> State=0, A=0 on the same edge, memory retained.
REQ-025 DATA_W=8, macro defined: A=0x7F, ADD of 0x01 -> Fault=1, Halt=1, Output=0x7F; macro undefined -> Output=0x80, Fault=0.
